// File: rtl/lsu_subword_ctrl.sv
// lsu_subword_ctrl: byte/halfword load-store front end for a word-wide memory.
// Sub-word stores run as read-modify-write; loads extract and extend the addressed lane.
module lsu_subword_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic [DATA_WIDTH-1:0] mem_a,
    output logic [DATA_WIDTH-1:0] mem_wd,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rd
);
    typedef enum logic {IDLE, MERGE} state_t;

    state_t                r_state, w_next;
    logic                  r_done, r_err;
    logic [DATA_WIDTH-1:0] r_load_data, r_merge, r_addr;
    logic                  w_accept, w_err, w_store, w_sub_store, w_load, w_sx;
    logic [DATA_WIDTH-1:0] w_aligned, w_mask, w_lane, w_merged, w_shift, w_ext;

    assign w_aligned   = {addr[DATA_WIDTH-1:2], 2'b00};
    assign w_err       = (funct3 == 3'b011) || (funct3[2:1] == 2'b11)
                      || (funct3[1:0] == 2'b01 && addr[0])
                      || (funct3 == 3'b010 && addr[1:0] != 2'b00)
                      || (req_we && funct3[2]);
    assign w_accept    = req_valid && r_state == IDLE;
    assign w_store     = w_accept && req_we && !w_err;
    assign w_sub_store = w_store && funct3 != 3'b010;
    assign w_load      = w_accept && !req_we && !w_err;

    // Replicating the store data across lanes lets one mask select the target lane.
    assign w_mask   = funct3[0] ? (32'h0000_FFFF << {addr[1], 4'b0000})
                                : (32'h0000_00FF << {addr[1:0], 3'b000});
    assign w_lane   = funct3[0] ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
    assign w_merged = (mem_rd & ~w_mask) | (w_lane & w_mask);

    assign w_shift = mem_rd >> {addr[1:0], 3'b000};
    assign w_sx    = !funct3[2];
    assign w_ext   = funct3[1] ? mem_rd
                   : funct3[0] ? {{16{w_sx & w_shift[15]}}, w_shift[15:0]}
                   : {{24{w_sx & w_shift[7]}}, w_shift[7:0]};

    always_comb begin
        w_next = IDLE;
        w_next = (r_state == IDLE && w_sub_store) ? MERGE : IDLE;
    end

    // Memory port is held quiet during reset even if a request is presented.
    assign mem_we = rst_n && (r_state == MERGE || (w_store && !w_sub_store));
    assign mem_a  = !rst_n ? '0 : (r_state == MERGE) ? r_addr : w_aligned;
    assign mem_wd = !mem_we ? '0 : (r_state == MERGE) ? r_merge : wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_load_data <= '0;
            r_merge     <= '0;
            r_addr      <= '0;
        end else begin
            r_state <= w_next;
            r_done  <= (w_accept && !w_sub_store) || r_state == MERGE;
            r_err   <= w_accept && w_err;
            if (w_accept && w_err)
                r_load_data <= '0;
            else if (w_load)
                r_load_data <= w_ext;
            if (w_sub_store) begin
                r_merge <= w_merged;
                r_addr  <= w_aligned;
            end
        end
    end

    assign busy      = r_state == MERGE;
    assign done      = r_done;
    assign err       = r_err;
    assign load_data = r_load_data;
endmodule

// File: tb/tb_lsu_subword_ctrl.sv
// tb_lsu_subword_ctrl: directed checks of lsu_subword_ctrl against a small word memory.
module tb_lsu_subword_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = '0, wdata = '0;
    logic        busy, done, err, mem_we;
    logic [31:0] load_data, mem_a, mem_wd, mem_rd;
    logic [31:0] mem [0:63];
    int          n_cmp = 0, n_bad = 0;

    lsu_subword_ctrl #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
        .funct3(funct3), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
        .err(err), .load_data(load_data), .mem_a(mem_a), .mem_wd(mem_wd),
        .mem_we(mem_we), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;
    assign mem_rd = mem[mem_a[7:2]];
    always @(posedge clk) if (mem_we) mem[mem_a[7:2]] <= mem_wd;

    task automatic drive(input logic v, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        req_valid = v; req_we = we; funct3 = f3; addr = a; wdata = wd;
    endtask

    task automatic step;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        drive(1, 1, 3'b010, 32'h10, 32'hCAFE_F00D);
        repeat (2) begin
            #2;
            n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
            n_cmp++; if (mem_a !== 32'h0) begin n_bad++; $display("FAIL reset_mem_a got=%h exp=0", mem_a); end
            n_cmp++; if (mem_wd !== 32'h0) begin n_bad++; $display("FAIL reset_mem_wd got=%h exp=0", mem_wd); end
            n_cmp++; if ({busy, done, err} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got=%b exp=000", {busy, done, err}); end
            n_cmp++; if (load_data !== 32'h0) begin n_bad++; $display("FAIL reset_load_data got=%h exp=0", load_data); end
            step();
        end
        drive(0, 0, 3'b000, 0, 0);
        rst_n = 1'b1;
        step();
        n_cmp++; if (mem[4] !== 32'h0) begin n_bad++; $display("FAIL reset_no_write got=%h exp=0", mem[4]); end
    endtask

    task automatic test_word_store_load;
        drive(1, 1, 3'b010, 32'h10, 32'hDEAD_BEEF);
        #1;
        n_cmp++; if ({mem_we, mem_a, mem_wd} !== {1'b1, 32'h10, 32'hDEAD_BEEF}) begin n_bad++; $display("FAIL sw_port got=%b/%h/%h exp=1/00000010/deadbeef", mem_we, mem_a, mem_wd); end
        step();
        drive(1, 0, 3'b010, 32'h10, 0);
        n_cmp++; if ({done, err, busy} !== 3'b100) begin n_bad++; $display("FAIL sw_done got=%b exp=100", {done, err, busy}); end
        n_cmp++; if (load_data !== 32'h0) begin n_bad++; $display("FAIL sw_load_data_held got=%h exp=0", load_data); end
        #1;
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL lw_mem_we got=%b exp=0", mem_we); end
        step();
        drive(0, 0, 3'b000, 0, 0);
        n_cmp++; if ({done, err, load_data} !== {2'b10, 32'hDEAD_BEEF}) begin n_bad++; $display("FAIL lw_result got=%b%b/%h exp=10/deadbeef", done, err, load_data); end
        step();
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL lw_done_pulse got=%b exp=0", done); end
    endtask

    task automatic test_subword_rmw;
        mem[4] = 32'h1122_3344;
        drive(1, 1, 3'b000, 32'h11, 32'h0000_00AA);
        #1;
        n_cmp++; if ({mem_we, mem_a} !== {1'b0, 32'h10}) begin n_bad++; $display("FAIL sb_accept got=%b/%h exp=0/00000010", mem_we, mem_a); end
        step();
        drive(0, 0, 3'b000, 0, 0);
        n_cmp++; if ({busy, done} !== 2'b10) begin n_bad++; $display("FAIL sb_merge_flags got=%b exp=10", {busy, done}); end
        n_cmp++; if ({mem_we, mem_a, mem_wd} !== {1'b1, 32'h10, 32'h1122_AA44}) begin n_bad++; $display("FAIL sb_merge_port got=%b/%h/%h exp=1/00000010/1122aa44", mem_we, mem_a, mem_wd); end
        step();
        n_cmp++; if ({busy, done, err} !== 3'b010) begin n_bad++; $display("FAIL sb_done got=%b exp=010", {busy, done, err}); end
        n_cmp++; if (mem[4] !== 32'h1122_AA44) begin n_bad++; $display("FAIL sb_mem got=%h exp=1122aa44", mem[4]); end
        drive(1, 1, 3'b001, 32'h12, 32'h1234_BEEF);
        step();
        drive(0, 0, 3'b000, 0, 0);
        n_cmp++; if ({busy, mem_we, mem_wd} !== {2'b11, 32'hBEEF_AA44}) begin n_bad++; $display("FAIL sh_merge got=%b%b/%h exp=11/beefaa44", busy, mem_we, mem_wd); end
        step();
        n_cmp++; if ({done, mem[4]} !== {1'b1, 32'hBEEF_AA44}) begin n_bad++; $display("FAIL sh_done got=%b/%h exp=1/beefaa44", done, mem[4]); end
        n_cmp++; if (load_data !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL store_keeps_load_data got=%h exp=deadbeef", load_data); end
    endtask

    task automatic test_load_ext;
        logic [31:0] a [7]  = '{32'h21, 32'h22, 32'h22, 32'h22, 32'h22, 32'h23, 32'h20};
        logic [2:0]  f [7]  = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b000};
        logic [31:0] e [7]  = '{32'h0000_007F, 32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_80FF,
                                32'h0000_80FF, 32'hFFFF_FF80, 32'h0000_0001};
        mem[8] = 32'h80FF_7F01;
        for (int i = 0; i < 7; i++) begin
            drive(1, 0, f[i], a[i], 0);
            step();
            n_cmp++; if ({done, err, load_data} !== {2'b10, e[i]}) begin n_bad++; $display("FAIL load_ext_%0d got=%b%b/%h exp=10/%h", i, done, err, load_data, e[i]); end
        end
        drive(0, 0, 3'b000, 0, 0);
        step();
    endtask

    task automatic test_errors;
        logic        w [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [2:0]  f [6] = '{3'b010, 3'b001, 3'b011, 3'b100, 3'b101, 3'b111};
        logic [31:0] a [6] = '{32'h13, 32'h11, 32'h10, 32'h10, 32'h10, 32'h10};
        for (int i = 0; i < 6; i++) begin
            drive(1, w[i], f[i], a[i], 32'h5A5A_5A5A);
            #1;
            n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL err_%0d_mem_we got=%b exp=0", i, mem_we); end
            step();
            n_cmp++; if ({done, err, busy, load_data} !== {3'b110, 32'h0}) begin n_bad++; $display("FAIL err_%0d got=%b%b%b/%h exp=110/00000000", i, done, err, busy, load_data); end
        end
        drive(0, 0, 3'b000, 0, 0);
        step();
        n_cmp++; if ({done, err, mem[4]} !== {2'b00, 32'hBEEF_AA44}) begin n_bad++; $display("FAIL err_mem_unchanged got=%b%b/%h exp=00/beefaa44", done, err, mem[4]); end
    endtask

    task automatic test_busy_and_reset;
        drive(1, 1, 3'b000, 32'h10, 32'h0000_0055);
        step();
        drive(1, 0, 3'b010, 32'h10, 0);
        #1;
        n_cmp++; if ({busy, done, mem_we, mem_wd} !== {3'b101, 32'hBEEF_AA55}) begin n_bad++; $display("FAIL busy_merge got=%b%b%b/%h exp=101/beefaa55", busy, done, mem_we, mem_wd); end
        step();
        n_cmp++; if ({busy, done, err, mem_we} !== 4'b0100) begin n_bad++; $display("FAIL busy_lw_accept got=%b exp=0100", {busy, done, err, mem_we}); end
        step();
        drive(0, 0, 3'b000, 0, 0);
        n_cmp++; if ({done, err, load_data} !== {2'b10, 32'hBEEF_AA55}) begin n_bad++; $display("FAIL busy_lw_result got=%b%b/%h exp=10/beefaa55", done, err, load_data); end
        step();
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL busy_single_done got=%b exp=0", done); end
        drive(1, 1, 3'b000, 32'h10, 32'h0000_0066);
        step();
        drive(0, 0, 3'b000, 0, 0);
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({busy, mem_we, mem_wd} !== {2'b00, 32'h0}) begin n_bad++; $display("FAIL rst_mid_merge got=%b%b/%h exp=00/00000000", busy, mem_we, mem_wd); end
        step();
        rst_n = 1'b1;
        n_cmp++; if ({done, load_data} !== {1'b0, 32'h0}) begin n_bad++; $display("FAIL rst_no_done got=%b/%h exp=0/00000000", done, load_data); end
        step();
        n_cmp++; if ({done, busy, mem[4]} !== {2'b00, 32'hBEEF_AA55}) begin n_bad++; $display("FAIL rst_no_write got=%b%b/%h exp=00/beefaa55", done, busy, mem[4]); end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        test_reset();
        test_word_store_load();
        test_subword_rmw();
        test_load_ext();
        test_errors();
        test_busy_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
